boot_ctrl: RTL and testbench

BOOT_CTRL -- requirements
Module: boot_ctrl

---
 rtl/boot_pkg.sv | 21 ++
 rtl/boot_counter.sv | 29 ++
 rtl/boot_ctrl.sv | 111 +++++++++++
 tb/tb_boot_ctrl.sv | 225 ++++++++++++++++++++++
 4 files changed

// File: rtl/boot_pkg.sv
// Shared definitions for the boot/PC-reload controller: state encoding,
// counter width, parameter defaults and an address alignment helper.
package boot_pkg;

    typedef enum logic [1:0] {
        BOOT  = 2'd0,
        LOAD  = 2'd1,
        DRAIN = 2'd2,
        IDLE  = 2'd3
    } bootState_e;

    localparam int unsigned CNT_W            = 8;
    localparam int unsigned HOLD_CYCLES_DEF  = 1;
    localparam int unsigned DRAIN_CYCLES_DEF = 4;
    localparam logic [31:0] RESET_ADDR_DEF   = 32'h0000_0000;

    function automatic logic isAligned(input logic [1:0] lowBits);
        return lowBits == 2'b00;
    endfunction

endpackage

// File: rtl/boot_counter.sv
// Loadable 8-bit down-counter with zero flag; saturates at 0.
// Ports: clk, rst (sync, high), load, loadValue -> zero.
module boot_counter
    import boot_pkg::*;
#(
    parameter logic [CNT_W-1:0] RESET_VALUE = '0
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             load,
    input  logic [CNT_W-1:0] loadValue,
    output logic             zero
);

    logic [CNT_W-1:0] count;

    always_ff @(posedge clk) begin
        if (rst) begin
            count <= RESET_VALUE;
        end else if (load) begin
            count <= loadValue;
        end else if (count != '0) begin
            count <= count - 1'b1;
        end
    end

    assign zero = (count == '0);

endmodule

// File: rtl/boot_ctrl.sv
// Boot / PC-reload controller: drives pcSelect/startAddress into the pipeline.
// Ports: clk, rst, req_valid/req_addr/req_ready, pcSelect, startAddress,
//        busy, load_done, addr_err.
module boot_ctrl
    import boot_pkg::*;
#(
    parameter int unsigned HOLD_CYCLES  = HOLD_CYCLES_DEF,
    parameter int unsigned DRAIN_CYCLES = DRAIN_CYCLES_DEF,
    parameter logic [31:0] RESET_ADDR   = RESET_ADDR_DEF
) (
    input  logic        clk,
    input  logic        rst,
    input  logic        req_valid,
    input  logic [31:0] req_addr,
    output logic        req_ready,
    output logic        pcSelect,
    output logic [31:0] startAddress,
    output logic        busy,
    output logic        load_done,
    output logic        addr_err
);

    // Counter holds "remaining cycles - 1", so zero marks the last cycle.
    localparam logic [CNT_W-1:0] HOLD_INIT = CNT_W'(HOLD_CYCLES - 1);
    localparam logic [CNT_W-1:0] DRAIN_INIT =
        (DRAIN_CYCLES == 0) ? '0 : CNT_W'(DRAIN_CYCLES - 1);

    bootState_e       state;
    bootState_e       nextState;
    logic             cntLoad;
    logic             cntZero;
    logic [CNT_W-1:0] cntInit;
    logic             accept;
    logic             loadDoneNext;
    logic             addrErrNext;

    boot_counter #(
        .RESET_VALUE(HOLD_INIT)
    ) uCounter (
        .clk      (clk),
        .rst      (rst),
        .load     (cntLoad),
        .loadValue(cntInit),
        .zero     (cntZero)
    );

    always_ff @(posedge clk) begin
        if (rst) begin
            state        <= BOOT;
            startAddress <= RESET_ADDR;
            load_done    <= 1'b0;
            addr_err     <= 1'b0;
        end else begin
            state     <= nextState;
            load_done <= loadDoneNext;
            addr_err  <= addrErrNext;
            if (accept) begin
                startAddress <= req_addr;
            end
        end
    end

    always_comb begin
        nextState    = state;
        accept       = 1'b0;
        loadDoneNext = 1'b0;
        addrErrNext  = 1'b0;
        unique case (state)
            BOOT, LOAD: begin
                if (cntZero) begin
                    nextState    = (DRAIN_CYCLES == 0) ? IDLE : DRAIN;
                    loadDoneNext = 1'b1;
                end
            end
            DRAIN: begin
                if (cntZero) begin
                    nextState = IDLE;
                end
            end
            IDLE: begin
                // Misaligned requests are consumed here and only flagged.
                if (req_valid) begin
                    if (isAligned(req_addr[1:0])) begin
                        accept    = 1'b1;
                        nextState = LOAD;
                    end else begin
                        addrErrNext = 1'b1;
                    end
                end
            end
            default: nextState = BOOT;
        endcase
    end

    // Reload the counter on every state entry.
    always_comb begin
        cntLoad = (nextState != state);
        cntInit = '0;
        unique case (nextState)
            BOOT, LOAD: cntInit = HOLD_INIT;
            DRAIN:      cntInit = DRAIN_INIT;
            IDLE:       cntInit = '0;
            default:    cntInit = '0;
        endcase
    end

    assign pcSelect  = (state == BOOT) || (state == LOAD);
    assign req_ready = (state == IDLE);
    assign busy      = (state != IDLE);

endmodule

// File: tb/tb_boot_ctrl.sv
// Directed bench for boot_ctrl: default instance (HOLD=1, DRAIN=4)
// and a HOLD=3, DRAIN=0 instance with a non-zero boot address.
module tb_boot_ctrl;

    logic        clk = 1'b0;
    logic        rst;
    logic        reqValid;
    logic [31:0] reqAddr;
    logic        reqReady;
    logic        pcSel;
    logic [31:0] startAddr;
    logic        busy;
    logic        loadDone;
    logic        addrErr;

    logic        rstB;
    logic        reqValidB;
    logic [31:0] reqAddrB;
    logic        reqReadyB;
    logic        pcSelB;
    logic [31:0] startAddrB;
    logic        busyB;
    logic        loadDoneB;
    logic        addrErrB;

    int nCompared = 0;
    int nMismatch = 0;
    int cnt;

    always #5 clk = ~clk;

    boot_ctrl dut (
        .clk         (clk),
        .rst         (rst),
        .req_valid   (reqValid),
        .req_addr    (reqAddr),
        .req_ready   (reqReady),
        .pcSelect    (pcSel),
        .startAddress(startAddr),
        .busy        (busy),
        .load_done   (loadDone),
        .addr_err    (addrErr)
    );

    boot_ctrl #(
        .HOLD_CYCLES (3),
        .DRAIN_CYCLES(0),
        .RESET_ADDR  (32'h8000_0000)
    ) dutB (
        .clk         (clk),
        .rst         (rstB),
        .req_valid   (reqValidB),
        .req_addr    (reqAddrB),
        .req_ready   (reqReadyB),
        .pcSelect    (pcSelB),
        .startAddress(startAddrB),
        .busy        (busyB),
        .load_done   (loadDoneB),
        .addr_err    (addrErrB)
    );

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic check(input string tag, input logic [31:0] obs,
                         input logic [31:0] exp);
        nCompared++;
        assert (obs === exp) else begin
            nMismatch++;
            $error("FAIL %s: observed %h expected %h", tag, obs, exp);
        end
    endtask

    initial begin
        rst = 1'b1;  reqValid = 1'b0;  reqAddr = '0;
        rstB = 1'b1; reqValidB = 1'b0; reqAddrB = '0;

        // Reset state
        tick();
        check("rst_pcsel", 32'(pcSel), 1);
        check("rst_addr", startAddr, 32'h0);
        check("rst_ready", 32'(reqReady), 0);
        check("rst_busy", 32'(busy), 1);
        check("rst_ldone", 32'(loadDone), 0);
        check("rst_aerr", 32'(addrErr), 0);

        // Power-on: first post-reset cycle is BOOT
        tick();
        rst = 1'b0;
        check("boot_pcsel", 32'(pcSel), 1);
        check("boot_addr", startAddr, 32'h0);

        tick();
        check("fall_pcsel", 32'(pcSel), 0);
        check("fall_ldone", 32'(loadDone), 1);
        check("fall_busy", 32'(busy), 1);
        check("fall_ready", 32'(reqReady), 0);
        for (int i = 0; i < 3; i++) begin
            tick();
            check("pwr_drain_ready", 32'(reqReady), 0);
            check("pwr_drain_ldone", 32'(loadDone), 0);
        end
        tick();
        check("pwr_idle_ready", 32'(reqReady), 1);
        check("pwr_idle_busy", 32'(busy), 0);

        // Aligned reload
        reqValid = 1'b1; reqAddr = 32'h0000_0100;
        tick();
        reqValid = 1'b0;
        check("ld_pcsel", 32'(pcSel), 1);
        check("ld_addr", startAddr, 32'h100);
        check("ld_ready", 32'(reqReady), 0);
        for (int i = 0; i < 4; i++) begin
            tick();
            check("ld_drain_pcsel", 32'(pcSel), 0);
            check("ld_drain_ready", 32'(reqReady), 0);
            check("ld_drain_busy", 32'(busy), 1);
            check("ld_drain_ldone", 32'(loadDone), (i == 0) ? 1 : 0);
        end
        tick();
        check("ld_idle_ready", 32'(reqReady), 1);

        // Misaligned request
        reqValid = 1'b1; reqAddr = 32'h0000_0102;
        tick();
        reqValid = 1'b0;
        check("mis_aerr", 32'(addrErr), 1);
        check("mis_ldone", 32'(loadDone), 0);
        check("mis_pcsel", 32'(pcSel), 0);
        check("mis_addr", startAddr, 32'h100);
        check("mis_ready", 32'(reqReady), 1);
        tick();
        check("mis_aerr_low", 32'(addrErr), 0);
        check("mis_pcsel2", 32'(pcSel), 0);

        // Back-pressure: request held from the LOAD cycle
        reqValid = 1'b1; reqAddr = 32'h0000_0180;
        tick();
        check("bp_first_addr", startAddr, 32'h180);
        reqAddr = 32'h0000_0200;
        cnt = 0;
        for (int i = 0; i < 11; i++) begin
            tick();
            if (pcSel) cnt++;
            if (i == 4) begin
                check("bp_idle_ready", 32'(reqReady), 1);
                check("bp_hold_addr", startAddr, 32'h180);
            end
            if (i == 5) begin
                check("bp_load_pcsel", 32'(pcSel), 1);
                check("bp_load_addr", startAddr, 32'h200);
                reqValid = 1'b0;
            end
        end
        check("bp_load_count", cnt, 1);
        check("bp_end_ready", 32'(reqReady), 1);

        // Reset mid-DRAIN, with a request during reset
        reqValid = 1'b1; reqAddr = 32'h0000_0300;
        tick();
        reqValid = 1'b0;
        tick();
        tick();
        check("rd_pre_pcsel", 32'(pcSel), 0);
        check("rd_pre_addr", startAddr, 32'h300);
        rst = 1'b1; reqValid = 1'b1; reqAddr = 32'h0000_0400;
        tick();
        rst = 1'b0; reqValid = 1'b0;
        check("rd_pcsel", 32'(pcSel), 1);
        check("rd_addr", startAddr, 32'h0);
        check("rd_ldone", 32'(loadDone), 0);
        check("rd_ready", 32'(reqReady), 0);
        cnt = 0;
        for (int i = 0; i < 5; i++) begin
            tick();
            if (loadDone) cnt++;
            check("rd_excl", 32'(loadDone & addrErr), 0);
        end
        check("rd_ldone_count", cnt, 1);
        check("rd_idle_ready", 32'(reqReady), 1);
        check("rd_idle_addr", startAddr, 32'h0);

        // HOLD=3, DRAIN=0 instance
        rstB = 1'b0;
        check("b_boot_addr", startAddrB, 32'h8000_0000);
        check("b_boot_ready", 32'(reqReadyB), 0);
        cnt = pcSelB ? 1 : 0;
        for (int i = 0; i < 2; i++) begin
            tick();
            if (pcSelB) cnt++;
        end
        tick();
        check("b_boot_len", cnt, 3);
        check("b_fall_pcsel", 32'(pcSelB), 0);
        check("b_fall_ready", 32'(reqReadyB), 1);
        check("b_fall_ldone", 32'(loadDoneB), 1);

        reqValidB = 1'b1; reqAddrB = 32'h0000_0040;
        tick();
        reqValidB = 1'b0;
        check("b_ld_addr", startAddrB, 32'h40);
        check("b_ld_ready", 32'(reqReadyB), 0);
        cnt = pcSelB ? 1 : 0;
        for (int i = 0; i < 2; i++) begin
            tick();
            if (pcSelB) cnt++;
        end
        tick();
        check("b_ld_len", cnt, 3);
        check("b_ld_fall_pcsel", 32'(pcSelB), 0);
        check("b_ld_fall_ready", 32'(reqReadyB), 1);
        check("b_ld_fall_ldone", 32'(loadDoneB), 1);
        check("b_ld_fall_aerr", 32'(addrErrB), 0);
        check("b_ld_hold_addr", startAddrB, 32'h40);
        check("b_idle_busy", 32'(busyB), 0);

        $display("*** SUMMARY: %0d compared / %0d mismatched ***",
                 nCompared, nMismatch);
        $finish;
    end

endmodule
